// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - data-memory initiator: byte/half/word loads and stores, sub-word read-modify-write
module load_store_unit #(
  parameter int MEM_WORDS = 64
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        req,
  input  logic        we,
  input  logic [1:0]  size,
  input  logic        sign_ext,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        done,
  output logic        err,
  output logic        busy,
  output logic [31:0] MemAddr,
  output logic [31:0] MemWdata,
  output logic        MemRead,
  output logic        MemWrite,
  input  logic [31:0] MemRdata
);

  localparam logic [1:0]  SIZE_BYTE = 2'b00;
  localparam logic [1:0]  SIZE_HALF = 2'b01;
  localparam logic [1:0]  SIZE_WORD = 2'b10;
  localparam logic [29:0] WORD_LIMIT = 30'(MEM_WORDS);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    STORE  = 3'd2,
    RMW_RD = 3'd3,
    RMW_WR = 3'd4
  } state_t;

  state_t      state;
  state_t      state_next;

  logic [31:0] addr_q;
  logic [1:0]  size_q;
  logic        sign_ext_q;
  logic [31:0] wdata_q;
  logic [31:0] merge_q;

  logic        accept;
  logic        req_bad;
  logic [7:0]  lane_byte;
  logic [15:0] lane_half;
  logic [31:0] load_val;
  logic [31:0] merge_val;

  assign accept  = (state == IDLE) && req;
  assign MemAddr = {2'b00, addr_q[31:2]};

  // Classify the incoming request: misaligned, unsupported size or beyond the memory
  always_comb begin
    req_bad = 1'b0;
    case (size)
      SIZE_BYTE: req_bad = 1'b0;
      SIZE_HALF: req_bad = addr[0];
      SIZE_WORD: req_bad = (addr[1:0] != 2'b00);
      default:   req_bad = 1'b1;
    endcase
    if (addr[31:2] >= WORD_LIMIT) begin
      req_bad = 1'b1;
    end
  end

  // State register
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decode; rejected requests never leave IDLE
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (accept && !req_bad) begin
          if (!we) begin
            state_next = LOAD;
          end else if (size == SIZE_WORD) begin
            state_next = STORE;
          end else begin
            state_next = RMW_RD;
          end
        end
      end
      LOAD:    state_next = IDLE;
      STORE:   state_next = IDLE;
      RMW_RD:  state_next = RMW_WR;
      RMW_WR:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Memory strobes come from registered state only, so reset kills them at once
  always_comb begin
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    MemWdata = 32'h0;
    busy     = (state != IDLE);
    case (state)
      LOAD:   MemRead = 1'b1;
      RMW_RD: MemRead = 1'b1;
      STORE: begin
        MemWrite = 1'b1;
        MemWdata = wdata_q;
      end
      RMW_WR: begin
        MemWrite = 1'b1;
        MemWdata = merge_q;
      end
      default: begin
        MemRead  = 1'b0;
        MemWrite = 1'b0;
      end
    endcase
  end

  // Little-endian lane selection from the returned memory word
  always_comb begin
    lane_byte = MemRdata[7:0];
    case (addr_q[1:0])
      2'd0: lane_byte = MemRdata[7:0];
      2'd1: lane_byte = MemRdata[15:8];
      2'd2: lane_byte = MemRdata[23:16];
      2'd3: lane_byte = MemRdata[31:24];
      default: lane_byte = MemRdata[7:0];
    endcase
    lane_half = addr_q[1] ? MemRdata[31:16] : MemRdata[15:0];
  end

  // Sign- or zero-extend the selected lane into the load result
  always_comb begin
    load_val = MemRdata;
    case (size_q)
      SIZE_BYTE: load_val = {{24{sign_ext_q & lane_byte[7]}}, lane_byte};
      SIZE_HALF: load_val = {{16{sign_ext_q & lane_half[15]}}, lane_half};
      default:   load_val = MemRdata;
    endcase
  end

  // Replace the target lane of the read word with the store data
  always_comb begin
    merge_val = MemRdata;
    if (size_q == SIZE_BYTE) begin
      case (addr_q[1:0])
        2'd0: merge_val[7:0]   = wdata_q[7:0];
        2'd1: merge_val[15:8]  = wdata_q[7:0];
        2'd2: merge_val[23:16] = wdata_q[7:0];
        2'd3: merge_val[31:24] = wdata_q[7:0];
        default: merge_val[7:0] = wdata_q[7:0];
      endcase
    end else if (addr_q[1]) begin
      merge_val[31:16] = wdata_q[15:0];
    end else begin
      merge_val[15:0] = wdata_q[15:0];
    end
  end

  // Request capture, result/merge registers and the done/err pulses
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      addr_q     <= 32'h0;
      size_q     <= 2'b00;
      sign_ext_q <= 1'b0;
      wdata_q    <= 32'h0;
      merge_q    <= 32'h0;
      rdata      <= 32'h0;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      if (accept) begin
        addr_q     <= addr;
        size_q     <= size;
        sign_ext_q <= sign_ext;
        wdata_q    <= wdata;
      end
      if (state == LOAD) begin
        rdata <= load_val;
      end
      if (state == RMW_RD) begin
        merge_q <= merge_val;
      end
      done <= (state == LOAD) || (state == STORE) || (state == RMW_WR) || (accept && req_bad);
      err  <= accept && req_bad;
    end
  end

endmodule
